// File: rtl/spi_xfer_slave.sv
// Oversampled SPI slave: receives a word, replies with a mode-selected transform.
// SPI_XFER_CHAIN_EN: keep exchanging words while ss stays low.
module spi_xfer_slave #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [1:0]       mode,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy
);

  localparam int   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-2:0] sh, sh_n;
  logic [WIDTH-1:0] tx, tx_n;
  logic [WIDTH-1:0] rx_data_n;
  logic [WIDTH-1:0] word;
  logic [1:0]       mode_q, mode_n;
  logic             pend, pend_n;
  logic             busy_n, miso_n, rx_valid_n;

  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_d, ss_d;
  logic sck_s, ss_s, mosi_s;
  logic rise, fall, sample, shift;
  logic ss_fall, ss_rise, last;

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign sample  = SCK_IDLE ? fall : rise;
  assign shift   = SCK_IDLE ? rise : fall;
  assign ss_fall = ~ss_s & ss_d;
  assign ss_rise = ss_s & ~ss_d;
  assign last    = (cnt == CW'(WIDTH - 1));
  assign word    = {sh, mosi_s};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_q  <= {SYNC_STAGES{SCK_IDLE}};
      ss_q   <= {SYNC_STAGES{1'b1}};
      mosi_q <= '0;
      sck_d  <= SCK_IDLE;
      ss_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_s;
      ss_d   <= ss_s;
    end
  end

  function automatic logic [WIDTH-1:0] xform(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    case (m)
      2'b00:   return r;
      2'b01:   return d;
      2'b10:   return ~d;
      default: return ~r;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      tx       <= '0;
      mode_q   <= '0;
      pend     <= 1'b0;
      busy     <= 1'b0;
      miso     <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      tx       <= tx_n;
      mode_q   <= mode_n;
      pend     <= pend_n;
      busy     <= busy_n;
      miso     <= miso_n;
      rx_valid <= rx_valid_n;
      rx_data  <= rx_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    tx_n       = tx;
    mode_n     = mode_q;
    pend_n     = pend;
    busy_n     = busy;
    rx_valid_n = 1'b0;
    rx_data_n  = rx_data;
    miso_n     = 1'b1;
    unique case (state)
      TX:      miso_n = tx[WIDTH-1];
      DONE:    miso_n = 1'b0;
      default: miso_n = 1'b1;
    endcase
    // ss release overrides everything, including a same-cycle sck edge
    if (ss_rise) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      cnt_n   = '0;
      miso_n  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            mode_n  = mode;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = RX;
          end
        end
        RX: begin
          if (sample) begin
            sh_n  = word[WIDTH-2:0];
            cnt_n = cnt + CW'(1);
            if (last) begin
              rx_data_n  = word;
              rx_valid_n = 1'b1;
              tx_n       = xform(mode_q, word);
              cnt_n      = '0;
              pend_n     = 1'b0;
              state_n    = TX;
            end
          end
        end
        TX: begin
          if (sample) begin
            cnt_n  = cnt + CW'(1);
            pend_n = 1'b1;
            if (last) begin
              cnt_n   = '0;
`ifdef SPI_XFER_CHAIN_EN
              state_n = RX;
`else
              state_n = DONE;
`endif
            end
          end else if (shift && pend) begin
            tx_n   = {tx[WIDTH-2:0], 1'b0};
            pend_n = 1'b0;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_slave.sv
// Bench for spi_xfer_slave: an 8-bit CPOL=0 and a 16-bit CPOL=1 instance
// driven by one bit-level SPI master model.
module tb_spi_xfer_slave;

  localparam int H = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       sel = 1'b0;
  logic       m_sck = 1'b0;
  logic       m_ss = 1'b1;
  logic       m_mosi = 1'b0;
  logic [1:0] mode = 2'b00;

  logic        sck_b, ss_a, ss_b;
  logic        miso_a, rx_valid_a, busy_a;
  logic        miso_b, rx_valid_b, busy_b;
  logic [7:0]  rx_data_a;
  logic [15:0] rx_data_b;

  assign ss_a  = sel ? 1'b1 : m_ss;
  assign ss_b  = sel ? m_ss : 1'b1;
  assign sck_b = ~m_sck;

  spi_xfer_slave #(.WIDTH(8), .CPOL(0), .SYNC_STAGES(2)) dut_a (
    .clock(clock), .reset(reset), .sck(m_sck), .ss(ss_a),
    .mosi(m_mosi), .miso(miso_a), .mode(mode),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a)
  );

  spi_xfer_slave #(.WIDTH(16), .CPOL(1), .SYNC_STAGES(2)) dut_b (
    .clock(clock), .reset(reset), .sck(sck_b), .ss(ss_b),
    .mosi(m_mosi), .miso(miso_b), .mode(mode),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ha = '0;
  logic [31:0] hb = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference transform built from the bit rules, not from the RTL
  function automatic logic [31:0] model(input logic [1:0] m,
                                        input logic [31:0] d,
                                        input int w);
    logic [31:0] r, mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | 32'(d[i]);
    case (m)
      2'b00:   return r;
      2'b01:   return d & mask;
      2'b10:   return ~d & mask;
      default: return ~r & mask;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid_a) begin
        if (qa.size() == 0) chk("spurious_rx_valid_a", 1, 0);
        else ha = qa.pop_front();
      end
      chk("rx_data_a", 32'(rx_data_a), ha);
      if (rx_valid_b) begin
        if (qb.size() == 0) chk("spurious_rx_valid_b", 1, 0);
        else hb = qb.pop_front();
      end
      chk("rx_data_b", 32'(rx_data_b), hb);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic cur_miso();
    return sel ? miso_b : miso_a;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy_b : busy_a;
  endfunction

  task automatic sbit(input logic din, output logic dout);
    m_mosi = din;
    wait_clk(H);
    dout = cur_miso();
    m_sck = 1'b1;
    wait_clk(H);
    m_sck = 1'b0;
  endtask

  task automatic begin_x(input logic s, input logic [1:0] m);
    sel = s;
    mode = m;
    wait_clk(2);
    m_ss = 1'b0;
    wait_clk(2 * H);
    chk("busy_on_select", 32'(cur_busy()), 1);
  endtask

  task automatic end_x();
    m_ss = 1'b1;
    wait_clk(2 * H);
    chk("busy_after_release", 32'(cur_busy()), 0);
    chk("miso_after_release", 32'(cur_miso()), 1);
  endtask

  task automatic run_word(input int w, input logic [31:0] d,
                          input logic rx_miso, input logic push,
                          output logic [31:0] reply);
    logic o, bad;
    bad = 1'b0;
    reply = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (i == 0 && push) begin
        if (sel) qb.push_back(d);
        else qa.push_back(d);
      end
      sbit(d[i], o);
      if (o !== rx_miso) bad = 1'b1;
    end
    chk("rx_phase_miso", 32'(bad), 0);
    for (int i = 0; i < w; i++) begin
      sbit(1'b0, o);
      reply = (reply << 1) | 32'(o);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic o;

    chk("model_rev_01", model(2'b00, 32'h01, 8), 32'h80);
    chk("model_inv_a5f0", model(2'b10, 32'hA5F0, 16), 32'h5A0F);
    chk("model_revinv_03", model(2'b11, 32'h03, 8), 32'h3F);
    chk("model_rev_55", model(2'b00, 32'h55, 8), 32'hAA);

    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    chk("reset_miso_a", 32'(miso_a), 1);
    chk("reset_busy_a", 32'(busy_a), 0);
    chk("reset_valid_a", 32'(rx_valid_a), 0);
    chk("reset_data_a", 32'(rx_data_a), 0);
    chk("reset_miso_b", 32'(miso_b), 1);
    chk("reset_busy_b", 32'(busy_b), 0);
    chk("reset_valid_b", 32'(rx_valid_b), 0);
    chk("reset_data_b", 32'(rx_data_b), 0);

    begin_x(1'b0, 2'b00);
    run_word(8, 32'h01, 1'b1, 1'b1, r);
    chk("reply_rev_01", r, 32'h80);
    chk("reply_rev_01_model", r, model(2'b00, 32'h01, 8));
    wait_clk(2 * H);
    chk("miso_done_a", 32'(miso_a), 0);
    end_x();

    begin_x(1'b1, 2'b10);
    run_word(16, 32'hA5F0, 1'b1, 1'b1, r);
    chk("reply_inv_a5f0", r, 32'h5A0F);
    wait_clk(2 * H);
    chk("miso_done_b", 32'(miso_b), 0);
    end_x();

    begin_x(1'b0, 2'b11);
    mode = 2'b00;
    run_word(8, 32'h03, 1'b1, 1'b1, r);
    chk("reply_revinv_03", r, 32'h3F);
    end_x();

    begin_x(1'b0, 2'b00);
    for (int i = 7; i >= 3; i--) sbit(i[0], o);
    end_x();
    chk("abort_held_data", 32'(rx_data_a), 32'h03);
    begin_x(1'b0, 2'b00);
    run_word(8, 32'h55, 1'b1, 1'b1, r);
    chk("reply_after_abort", r, 32'hAA);
    end_x();

    begin_x(1'b0, 2'b01);
    run_word(8, 32'h12, 1'b1, 1'b1, r);
    chk("chain_reply_1", r, 32'h12);
`ifdef SPI_XFER_CHAIN_EN
    run_word(8, 32'h34, 1'b1, 1'b1, r);
    chk("chain_reply_2", r, 32'h34);
`else
    run_word(8, 32'h34, 1'b0, 1'b0, r);
    chk("ignored_reply_2", r, 32'h00);
    chk("ignored_miso", 32'(miso_a), 0);
`endif
    end_x();

    wait_clk(10);
    chk("pending_valid_a", 32'(qa.size()), 0);
    chk("pending_valid_b", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
